seg7_scan_driver: RTL and testbench

- Downstream of the time/date display interface; consumes its eight BCD/code digits, decimal-point mask and blink controls.
- Time-multiplexes them onto an 8-digit common-anode seven-segment display and applies per-digit blinking.
- Inputs are snapshotted once per scan frame, so a digit set never tears mid-frame.

---
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scanner with per-frame snapshot and blink.
// Optional anode guard interval at slot start: SEG_GHOST_BLANK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_DIV    = 25000000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  point,
  input  logic [7:0]  which_shine,
  input  logic        is_shine,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          load_pending;

  logic [31:0]   snap_digits;
  logic [7:0]    snap_point;
  logic [7:0]    snap_ws;
  logic          snap_shine;

  logic          tick;
  logic          load;
  logic [3:0]    nib;
  logic          hidden;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign tick = (scan_cnt == SCAN_LAST);
  assign load = load_pending || (tick && idx == 3'd7);
  assign nib  = snap_digits[{idx, 2'b00} +: 4];
  assign hidden = snap_shine && snap_ws[idx] && !blink_phase;

  always_comb begin
    an_d  = ~(8'b1 << idx);
    seg_d = 7'h7F;
    dp_d  = snap_point[idx];
    case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0111111;
      default: seg_d = 7'h7F;
    endcase
    if (hidden) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
`ifdef SEG_GHOST_BLANK_EN
    // Segments still settle while the anode stays off.
    if (scan_cnt < SW'(BLANK_CYCLES)) an_d = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt     <= '0;
      idx          <= 3'd0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
      load_pending <= 1'b1;
      snap_digits  <= 32'hFFFF_FFFF;
      snap_point   <= 8'hFF;
      snap_ws      <= 8'h00;
      snap_shine   <= 1'b0;
      frame_start  <= 1'b0;
      an           <= 8'hFF;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      load_pending <= 1'b0;
      frame_start  <= load;
      if (load) begin
        snap_digits <= digits;
        snap_point  <= point;
        snap_ws     <= which_shine;
        snap_shine  <= is_shine;
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLINK_DIV=8.
// Expected outputs derive from the cycle count since reset release.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  point;
  logic [7:0]  which_shine;
  logic        is_shine;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] m_digits;
  logic [7:0]  m_point;
  logic [7:0]  m_ws;
  logic        m_shine;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .SCAN_DIV(4),
    .BLINK_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digits(digits),
    .point(point),
    .which_shine(which_shine),
    .is_shine(is_shine),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_tab(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_digits = 32'hFFFF_FFFF;
    m_point  = 8'hFF;
    m_ws     = 8'h00;
    m_shine  = 1'b0;
  endtask

  // Outputs after edge c reflect the slot/phase state before that edge.
  task automatic check_cycle();
    int s;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    logic hid;
    logic ghost;
    s = ((cyc - 1) / 4) % 8;
    hid = m_shine && m_ws[s] && ((((cyc - 1) / 8) % 2) == 1);
    e_an = ~(8'b1 << s);
    e_seg = seg_tab(m_digits[s*4 +: 4]);
    e_dp = m_point[s];
    if (hid) begin
      e_an = 8'hFF;
      e_seg = 7'h7F;
      e_dp = 1'b1;
    end
    ghost = 1'b0;
`ifdef SEG_GHOST_BLANK_EN
    ghost = ((cyc - 1) % 4) < 2;
`endif
    if (ghost) e_an = 8'hFF;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start),
        32'((cyc == 1) || (cyc % 32 == 0)));
    if (cyc == 1 || cyc % 32 == 0) begin
      m_digits = digits;
      m_point  = point;
      m_ws     = which_shine;
      m_shine  = is_shine;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_reset_state();
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    digits = 32'h8765_4321;
    point = 8'hFF;
    which_shine = 8'h00;
    is_shine = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();

    reset = 1'b0;
    cyc = 0;
    run_to(10);
    // Mid-frame change must wait for the next frame load.
    digits = 32'h12A3_4A56;
    point = 8'b1110_1011;
    run_to(66);
    is_shine = 1'b1;
    which_shine = 8'h03;
    run_to(100);
    which_shine = 8'h0C;
    run_to(130);
    which_shine = 8'hFF;
    run_to(162);
    is_shine = 1'b0;
    run_to(205);

    // Reset in the middle of a frame.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    digits = 32'h8765_4321;
    point = 8'hFF;
    which_shine = 8'hFF;
    is_shine = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    model_reset();
    reset = 1'b0;
    cyc = 0;
    run_to(70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
